// File: rtl/uart_rx_ctrl.sv
// Receive-side UART controller: re-arms the receiver after each captured byte
// and buffers bytes in a small FIFO exposed to the CPU as a 16-bit register.
module uart_rx_ctrl #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              rx_out,
    output logic                     rx_reset,
    input  logic                     load,
    input  logic [15:0]              in,
    output logic [15:0]              out,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_ARM,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t        r_state;
    logic          r_rx_reset;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overrun;
    logic [7:0]    r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_capture;
    logic w_flush;
    logic w_pop;
    logic w_push;
    logic w_unused;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == C_FULL);
    assign w_capture = (r_state == S_CAPTURE);
    assign w_flush   = load & in[15];
    assign w_pop     = load & ~in[15] & ~w_empty;
    // A same-cycle pop frees a slot, so a capture into a full FIFO still lands.
    assign w_push    = w_capture & ~w_flush & (~w_full | w_pop);
    assign w_unused  = &{1'b0, in[14:0], rx_out[14:8]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_ARM;
            r_rx_reset <= 1'b1;
        end else begin
            case (r_state)
                S_ARM: begin
                    r_state    <= S_WAIT;
                    r_rx_reset <= 1'b0;
                end
                S_WAIT: begin
                    if (!rx_out[15]) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_state    <= S_ARM;
                    r_rx_reset <= 1'b1;
                end
                default: begin
                    r_state    <= S_ARM;
                    r_rx_reset <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else if (w_flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
            if (w_capture && !w_push) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_out[7:0];
        end
    end

    assign rx_reset = r_rx_reset;
    assign count    = r_count;
    assign out      = {w_empty, r_overrun, 6'b0, (w_empty ? 8'h00 : r_mem[r_rd_ptr])};

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl with DEPTH=4.
module tb_uart_rx_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] rx_out;
    logic        rx_reset;
    logic        load;
    logic [15:0] in;
    logic [15:0] out;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    uart_rx_ctrl #(.DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_out   (rx_out),
        .rx_reset (rx_reset),
        .load     (load),
        .in       (in),
        .out      (out),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver model: byte held from the WAIT cycle until the ARM cycle that follows capture.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_out = {8'h00, b};
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rx_out = 16'h8000;
        @(posedge clk);
    endtask

    task automatic test_reset;
        reset  = 1'b0;
        rx_out = 16'h8000;
        load   = 1'b0;
        in     = 16'h0000;
        repeat (2) @(negedge clk);
        checks++;
        if (out !== 16'h8000) begin errors++; $display("FAIL reset_out got=%h exp=8000", out); end
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++;
        if (rx_reset !== 1'b1) begin errors++; $display("FAIL reset_rxr got=%b exp=1", rx_reset); end
        reset = 1'b1;
        #1;
        checks++;
        if (rx_reset !== 1'b1) begin errors++; $display("FAIL release_rxr_hi got=%b exp=1", rx_reset); end
        @(negedge clk);
        checks++;
        if (rx_reset !== 1'b0) begin errors++; $display("FAIL release_rxr_lo got=%b exp=0", rx_reset); end
    endtask

    task automatic test_single_byte;
        @(negedge clk);
        rx_out = 16'h0041;
        @(negedge clk);
        checks++;
        if (out !== 16'h8000 || count !== 3'd0 || rx_reset !== 1'b0) begin
            errors++; $display("FAIL single_k out=%h cnt=%0d rxr=%b exp 8000/0/0", out, count, rx_reset);
        end
        @(negedge clk);
        checks++;
        if (out !== 16'h0041 || count !== 3'd1) begin
            errors++; $display("FAIL single_k1 out=%h cnt=%0d exp 0041/1", out, count);
        end
        checks++;
        if (rx_reset !== 1'b1) begin errors++; $display("FAIL single_rxr_pulse got=%b exp=1", rx_reset); end
        rx_out = 16'h8000;
        @(negedge clk);
        checks++;
        if (rx_reset !== 1'b0) begin errors++; $display("FAIL single_rxr_end got=%b exp=0", rx_reset); end
        load = 1'b1;
        in   = 16'h0000;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (out !== 16'h8000 || count !== 3'd0) begin
            errors++; $display("FAIL single_pop out=%h cnt=%0d exp 8000/0", out, count);
        end
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (out !== 16'h8000 || count !== 3'd0) begin
            errors++; $display("FAIL empty_pop out=%h cnt=%0d exp 8000/0", out, count);
        end
    endtask

    task automatic pop_expect(input logic [15:0] exp, input int tag);
        @(negedge clk);
        checks++;
        if (out !== exp) begin errors++; $display("FAIL pop_head_%0d got=%h exp=%h", tag, out, exp); end
        load = 1'b1;
        in   = 16'h0000;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_order_wrap;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        pop_expect(16'h0001, 1);
        send_byte(8'h04);
        pop_expect(16'h0002, 2);
        send_byte(8'h05);
        pop_expect(16'h0003, 3);
        send_byte(8'h06);
        checks++;
        if (count !== 3'd3) begin errors++; $display("FAIL wrap_count got=%0d exp=3", count); end
        pop_expect(16'h0004, 4);
        pop_expect(16'h0005, 5);
        pop_expect(16'h0006, 6);
        checks++;
        if (out !== 16'h8000 || count !== 3'd0) begin
            errors++; $display("FAIL wrap_end out=%h cnt=%0d exp 8000/0", out, count);
        end
    endtask

    task automatic test_overrun;
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
        @(negedge clk);
        checks++;
        if (out !== 16'h4010 || count !== 3'd4) begin
            errors++; $display("FAIL overrun_full out=%h cnt=%0d exp 4010/4", out, count);
        end
        for (int i = 0; i < 4; i++) pop_expect(16'h4010 + 16'(i), 10 + i);
        checks++;
        if (out !== 16'hC000 || count !== 3'd0) begin
            errors++; $display("FAIL overrun_empty out=%h cnt=%0d exp C000/0", out, count);
        end
        load = 1'b1;
        in   = 16'h8000;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (out !== 16'h8000) begin errors++; $display("FAIL flush_clear got=%h exp=8000", out); end
    endtask

    task automatic test_full_pop;
        for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i));
        @(negedge clk);
        rx_out = 16'h0055;
        @(negedge clk);
        load = 1'b1;
        in   = 16'h0000;
        @(negedge clk);
        load   = 1'b0;
        rx_out = 16'h8000;
        checks++;
        if (count !== 3'd4 || out !== 16'h0021) begin
            errors++; $display("FAIL full_pop out=%h cnt=%0d exp 0021/4", out, count);
        end
        @(posedge clk);
        pop_expect(16'h0021, 21);
        pop_expect(16'h0022, 22);
        pop_expect(16'h0023, 23);
        pop_expect(16'h0055, 55);
        checks++;
        if (out !== 16'h8000) begin errors++; $display("FAIL full_pop_end got=%h exp=8000", out); end
    endtask

    task automatic test_flush_priority;
        for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i));
        @(negedge clk);
        rx_out = 16'h0066;
        @(negedge clk);
        load = 1'b1;
        in   = 16'h8000;
        @(negedge clk);
        load   = 1'b0;
        rx_out = 16'h8000;
        checks++;
        if (out !== 16'h8000 || count !== 3'd0) begin
            errors++; $display("FAIL flush_prio out=%h cnt=%0d exp 8000/0", out, count);
        end
        @(posedge clk);
        send_byte(8'h77);
        @(negedge clk);
        checks++;
        if (out !== 16'h0077 || count !== 3'd1) begin
            errors++; $display("FAIL flush_after out=%h cnt=%0d exp 0077/1", out, count);
        end
    endtask

    task automatic test_reset_midframe;
        @(negedge clk);
        rx_out = 16'h0088;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (out !== 16'h8000 || count !== 3'd0 || rx_reset !== 1'b1) begin
            errors++; $display("FAIL midreset out=%h cnt=%0d rxr=%b exp 8000/0/1", out, count, rx_reset);
        end
        @(negedge clk);
        rx_out = 16'h8000;
        reset  = 1'b1;
        #1;
        checks++;
        if (rx_reset !== 1'b1) begin errors++; $display("FAIL midreset_rel_hi got=%b exp=1", rx_reset); end
        @(negedge clk);
        checks++;
        if (rx_reset !== 1'b0 || out !== 16'h8000) begin
            errors++; $display("FAIL midreset_rel_lo rxr=%b out=%h exp 0/8000", rx_reset, out);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_order_wrap();
        test_overrun();
        test_full_pop();
        test_flush_priority();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller that sequences the UART receiver and buffers its bytes for the Hack CPU. It re-arms the receiver after every captured byte and pushes bytes into a small FIFO. It presents the FIFO head as a memory-mapped 16-bit register, so the CPU can fall behind by up to DEPTH bytes without losing data. It sits between the UART receiver and the CPU memory-mapped I/O decode.

## Interface

- DEPTH, 4: FIFO entries; power of two, ≥2.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; clears FIFO and state when 0.
- rx_out  input  16  UART receiver output; [15]=0 means a valid byte is in [7:0].
- rx_reset  output  1  active-high re-arm to the UART receiver; reset value 1.
- load  input  1  CPU write strobe to this register.
- in  input  16  CPU write data; only [15] is decoded.
- out  output  16  CPU read value; reset value 16'h8000.
- count  output  log2(DEPTH)+1  FIFO occupancy; reset value 0.

## Operation

- FSM states:
  - ARM (reset state): rx_reset=1; always go to WAIT next cycle.
  - WAIT: rx_reset=0; go to CAPTURE when rx_out[15]==0, otherwise stay.
  - CAPTURE: rx_reset=0; handle rx_out[7:0] (below); always go to ARM.
- rx_reset is a Moore output: 1 exactly when state==ARM, including while reset is asserted.
- Push, in CAPTURE:
  - If not full, or a pop happens in the same cycle, write rx_out[7:0] at the write pointer.
  - Otherwise drop the byte and set the sticky overrun flag.
- Pop: load=1 with in[15]=0 and FIFO non-empty advances the read pointer. load=1 on an empty FIFO does nothing.
- Flush: load=1 with in[15]=1 zeroes both pointers, count and overrun. It takes priority over a same-cycle push (byte discarded, overrun stays 0) and over pop.
- Simultaneous push and pop: both take effect and count is unchanged. This holds when full, so no overrun.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count = pushes − pops and saturates nowhere (invariant 0..DEPTH).
- out is combinational from registered state:
  - out[15] = empty.
  - out[14] = overrun.
  - out[13:8] = 0.
  - out[7:0] = FIFO head byte, or 8'h00 when empty.
- Asynchronous reset while reset=0: state=ARM, pointers=0, count=0, overrun=0, so out=16'h8000 and rx_reset=1. This also aborts a byte in flight: the receiver is held re-armed and the partial frame is lost.

## Timing

- Edge k: WAIT samples rx_out[15]==0, so CAPTURE is the state after edge k.
- Edge k+1: byte written, count updated, state=ARM. out shows the byte after edge k+1 if the FIFO was empty.
- Edge k+2: state=WAIT, rx_reset back to 0. rx_reset is high for exactly one cycle per captured byte.
- A frame must not start within the 2 cycles after rx_out[15] falls. This is guaranteed because one stop bit lasts many clk cycles.
- Pop and flush take effect at the edge where load=1, and out reflects the new head in the following cycle.
- No combinational path from rx_out or load/in to out or rx_reset.

## Test plan

- Reset: drive reset=0 mid-operation → out=16'h8000, count=0, rx_reset=1. Release → rx_reset=1 for one cycle, then 0.
- Single byte: receiver model presents rx_out=16'h0041 → exactly 2 cycles later out=16'h0041 and count=1. rx_reset pulses for 1 cycle. load=1, in=0 → out=16'h8000, count=0.
- Order and wrap: receive 8'h01..8'h06 while popping after each third byte (DEPTH=4) → bytes read back in order 01..06, pointers wrap, no overrun.
- Overrun: receive 5 bytes 8'h10..8'h14 with no pops → count=4, out=16'h4010, byte 8'h14 dropped. Pops return 10,11,12,13, then out=16'hC000 (empty and overrun).
- Full with same-cycle pop: FIFO full, pop asserted in the CAPTURE cycle of byte 8'h55 → count stays 4, out[14]=0, 8'h55 read last.
- Flush priority: load=1, in=16'h8000 in a CAPTURE cycle → count=0, overrun cleared, captured byte discarded, out=16'h8000.
